// File: rtl/cu_pkg.sv
// Shared definitions for the microprogrammed sequencer: sequencing ops,
// controller states and microword field geometry.
package cu_pkg;

    typedef enum logic [2:0] {
        SEQ_NEXT     = 3'd0,
        SEQ_JUMP     = 3'd1,
        SEQ_JUMPZ    = 3'd2,
        SEQ_JUMPNZ   = 3'd3,
        SEQ_DISPATCH = 3'd4,
        SEQ_CALL     = 3'd5,
        SEQ_RET      = 3'd6,
        SEQ_HALT     = 3'd7
    } seq_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT,
        ST_ERR
    } state_t;

    localparam int OP_W = 3;

    function automatic int fsel_w(input int nflags);
        return (nflags <= 1) ? 1 : $clog2(nflags);
    endfunction

    function automatic int word_w(input int nflags, input int upc_w, input int cw_w);
        return OP_W + fsel_w(nflags) + upc_w + cw_w;
    endfunction

    // Microword layout, MSB to LSB: op | fsel | target | ctrl
    function automatic int target_lsb(input int cw_w);
        return cw_w;
    endfunction

    function automatic int fsel_lsb(input int upc_w, input int cw_w);
        return cw_w + upc_w;
    endfunction

    function automatic int op_lsb(input int nflags, input int upc_w, input int cw_w);
        return cw_w + upc_w + fsel_w(nflags);
    endfunction

endpackage

// File: rtl/cu_control_store.sv
// Microword RAM: synchronous write, asynchronous read, no reset so contents
// survive a controller reset.
module cu_control_store #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 48
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/microseq_control_unit.sv
// Microprogrammed sequencer: fetches store[upc], drives its ctrl field and
// computes the next micro-PC with jump, dispatch and CALL/RET support.
module microseq_control_unit
    import cu_pkg::*;
#(
    parameter int UPC_W         = 6,
    parameter int CW_W          = 38,
    parameter int NFLAGS        = 2,
    parameter int STACK_DEPTH   = 4,
    parameter int START_ADDR    = 0,
    parameter int DISPATCH_BASE = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    enable,
    input  logic                                    start,
    input  logic [NFLAGS-1:0]                       flags,
    input  logic [UPC_W-1:0]                        MBRU,
    input  logic                                    ld_en,
    input  logic [UPC_W-1:0]                        ld_addr,
    input  logic [word_w(NFLAGS, UPC_W, CW_W)-1:0]  ld_data,
    output logic [CW_W-1:0]                         control_signal,
    output logic [UPC_W-1:0]                        upc,
    output logic                                    busy,
    output logic                                    finish,
    output logic                                    error
);

    localparam int WORD_W = word_w(NFLAGS, UPC_W, CW_W);
    localparam int FSEL_W = fsel_w(NFLAGS);
    localparam int SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [UPC_W-1:0] START_UPC    = UPC_W'(START_ADDR);
    localparam logic [UPC_W-1:0] DISPATCH_OFS = UPC_W'(DISPATCH_BASE);
    localparam logic [SP_W-1:0]  SP_FULL      = SP_W'(STACK_DEPTH);

    state_t            state, state_n;
    logic [UPC_W-1:0]  upc_n, upc_inc, target, ret_addr;
    logic [SP_W-1:0]   sp, sp_n, sp_dec;
    logic [WORD_W-1:0] word;
    logic [FSEL_W-1:0] fsel;
    seq_op_t           op;
    logic              flag, push, store_we;
    logic [UPC_W-1:0]  stack [STACK_DEPTH];

    assign store_we = ld_en && (state != ST_RUN) && rst_n;

    cu_control_store #(
        .ADDR_W (UPC_W),
        .DATA_W (WORD_W)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (upc),
        .rdata (word)
    );

    assign op       = seq_op_t'(word[op_lsb(NFLAGS, UPC_W, CW_W) +: OP_W]);
    assign fsel     = word[fsel_lsb(UPC_W, CW_W) +: FSEL_W];
    assign target   = word[target_lsb(CW_W) +: UPC_W];
    assign upc_inc  = upc + UPC_W'(1);
    assign sp_dec   = sp - SP_W'(1);
    assign ret_addr = stack[sp_dec[IDX_W-1:0]];

    // Out-of-range selectors fall back to flag 0
    always_comb begin
        flag = flags[0];
        for (int unsigned i = 0; i < NFLAGS; i++) begin
            if (32'(fsel) == i) flag = flags[i];
        end
    end

    always_comb begin
        state_n = state;
        upc_n   = upc;
        sp_n    = sp;
        push    = 1'b0;
        case (state)
            ST_RUN: begin
                if (enable) begin
                    case (op)
                        SEQ_NEXT:     upc_n = upc_inc;
                        SEQ_JUMP:     upc_n = target;
                        SEQ_JUMPZ:    upc_n = flag ? target : upc_inc;
                        SEQ_JUMPNZ:   upc_n = flag ? upc_inc : target;
                        SEQ_DISPATCH: upc_n = MBRU + DISPATCH_OFS;
                        SEQ_CALL: begin
                            if (sp == SP_FULL) begin
                                state_n = ST_ERR;
                            end else begin
                                push  = 1'b1;
                                upc_n = target;
                                sp_n  = sp + SP_W'(1);
                            end
                        end
                        SEQ_RET: begin
                            if (sp == '0) begin
                                state_n = ST_ERR;
                            end else begin
                                upc_n = ret_addr;
                                sp_n  = sp_dec;
                            end
                        end
                        SEQ_HALT:     state_n = ST_HALT;
                    endcase
                end
            end
            default: begin
                if (start) begin
                    state_n = ST_RUN;
                    upc_n   = START_UPC;
                    sp_n    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            upc   <= '0;
            sp    <= '0;
        end else begin
            state <= state_n;
            upc   <= upc_n;
            sp    <= sp_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            stack[sp[IDX_W-1:0]] <= upc_inc;
        end
    end

    assign control_signal = (state == ST_RUN && enable) ? word[CW_W-1:0] : '0;
    assign busy           = (state == ST_RUN);
    assign finish         = (state == ST_HALT);
    assign error          = (state == ST_ERR);

endmodule

// File: tb/tb_microseq_control_unit.sv
// Self-checking bench: directed scenarios plus randomized programs, checked
// every cycle against a behavioural model of the sequencer.
module tb_microseq_control_unit;

    localparam int UPC_W       = 6;
    localparam int CW_W        = 38;
    localparam int NFLAGS      = 2;
    localparam int STACK_DEPTH = 4;
    localparam int WORD_W      = 3 + 1 + UPC_W + CW_W;
    localparam int DEPTH       = 64;
    localparam int START       = 0;
    localparam int DBASE       = 0;

    localparam int OP_NEXT = 0, OP_JUMP = 1, OP_JUMPZ = 2, OP_JUMPNZ = 3;
    localparam int OP_DISPATCH = 4, OP_CALL = 5, OP_RET = 6, OP_HALT = 7;

    logic              clk, rst_n, enable, start, ld_en;
    logic [NFLAGS-1:0] flags;
    logic [UPC_W-1:0]  mbru, ld_addr;
    logic [WORD_W-1:0] ld_data;
    logic [CW_W-1:0]   control_signal;
    logic [UPC_W-1:0]  upc;
    logic              busy, finish, error;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int             op;
        int             fsel;
        int             target;
        logic [CW_W-1:0] ctrl;
    } uword_t;

    uword_t mem [DEPTH];
    string  m_mode;
    int     m_upc;
    int     m_stack [$];

    microseq_control_unit #(
        .UPC_W         (UPC_W),
        .CW_W          (CW_W),
        .NFLAGS        (NFLAGS),
        .STACK_DEPTH   (STACK_DEPTH),
        .START_ADDR    (START),
        .DISPATCH_BASE (DBASE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .start          (start),
        .flags          (flags),
        .MBRU           (mbru),
        .ld_en          (ld_en),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .control_signal (control_signal),
        .upc            (upc),
        .busy           (busy),
        .finish         (finish),
        .error          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_mode = "idle";
        m_upc  = 0;
        m_stack.delete();
    endtask

    task automatic check_all(input string tag);
        logic [CW_W-1:0] exp_cs;
        exp_cs = (m_mode == "run" && enable) ? mem[m_upc].ctrl : '0;
        check({tag, ".upc"},    64'(upc),            64'(m_upc));
        check({tag, ".busy"},   64'(busy),           64'(m_mode == "run"));
        check({tag, ".finish"}, 64'(finish),         64'(m_mode == "halt"));
        check({tag, ".error"},  64'(error),          64'(m_mode == "err"));
        check({tag, ".ctrl"},   64'(control_signal), 64'(exp_cs));
    endtask

    task automatic exec_word();
        uword_t w;
        int     nxt;
        logic   f;
        w   = mem[m_upc];
        nxt = (m_upc + 1) % DEPTH;
        f   = flags[(w.fsel < NFLAGS) ? w.fsel : 0];
        case (w.op)
            OP_NEXT:     m_upc = nxt;
            OP_JUMP:     m_upc = w.target;
            OP_JUMPZ:    m_upc = f ? w.target : nxt;
            OP_JUMPNZ:   m_upc = f ? nxt : w.target;
            OP_DISPATCH: m_upc = (int'(mbru) + DBASE) % DEPTH;
            OP_CALL: begin
                if (m_stack.size() == STACK_DEPTH) m_mode = "err";
                else begin
                    m_stack.push_back(nxt);
                    m_upc = w.target;
                end
            end
            OP_RET: begin
                if (m_stack.size() == 0) m_mode = "err";
                else m_upc = m_stack.pop_back();
            end
            default: m_mode = "halt";
        endcase
    endtask

    // Called right after a rising edge, while inputs still hold their pre-edge values
    task automatic model_edge();
        string was;
        was = m_mode;
        if (!rst_n) begin
            reset_model();
            return;
        end
        if (was == "run") begin
            if (enable) exec_word();
        end else if (start) begin
            m_mode = "run";
            m_upc  = START;
            m_stack.delete();
        end
        if (ld_en && was != "run") begin
            mem[ld_addr].op     = int'(ld_data[WORD_W-1 -: 3]);
            mem[ld_addr].fsel   = int'(ld_data[CW_W+UPC_W]);
            mem[ld_addr].target = int'(ld_data[CW_W +: UPC_W]);
            mem[ld_addr].ctrl   = ld_data[CW_W-1:0];
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic load(input int addr, input int op, input int fsel, input int tgt,
                        input logic [CW_W-1:0] ctrl);
        ld_en   = 1'b1;
        ld_addr = UPC_W'(addr);
        ld_data = {3'(op), 1'(fsel), 6'(tgt), ctrl};
        cycle("load");
        ld_en   = 1'b0;
    endtask

    task automatic start_prog(input string tag);
        start  = 1'b1;
        enable = 1'b1;
        cycle(tag);
        start  = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        reset_model();
        #1;
        check_all(tag);
        cycle({tag, "_hold"});
        rst_n = 1'b1;
    endtask

    task automatic flag_jump(input logic [NFLAGS-1:0] fv, input int exp_upc, input string tag);
        flags = fv;
        start_prog({tag, "_start"});
        cycle({tag, "_jump0"});
        cycle({tag, "_cond"});
        check({tag, "_target"}, 64'(upc), 64'(exp_upc));
        cycle({tag, "_halt"});
    endtask

    initial begin
        logic [63:0] r;
        rst_n = 1'b0; enable = 1'b0; start = 1'b0; ld_en = 1'b0;
        flags = '0; mbru = '0; ld_addr = '0; ld_data = '0;
        reset_model();
        #2;
        check_all("reset");
        repeat (2) cycle("rst_hold");
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) load(i, OP_HALT, 0, 0, '0);

        // Straight-line program ending in HALT
        load(0, OP_NEXT, 0, 0, 38'h1);
        load(1, OP_NEXT, 0, 0, 38'h2);
        load(2, OP_HALT, 0, 0, 38'h3);
        start_prog("s1_start");
        check("s1_cs0", 64'(control_signal), 64'h1);
        cycle("s1_c1");
        check("s1_cs1", 64'(control_signal), 64'h2);
        cycle("s1_c2");
        check("s1_cs2", 64'(control_signal), 64'h3);
        cycle("s1_c3");
        check("s1_finish", 64'(finish), 64'h1);
        check("s1_busy", 64'(busy), 64'h0);
        check("s1_cs_end", 64'(control_signal), 64'h0);

        // Conditional jumps on flag 0
        load(0, OP_JUMP, 0, 5, 38'h10);
        load(5, OP_JUMPNZ, 0, 47, 38'h11);
        load(6, OP_HALT, 0, 0, 38'h12);
        load(47, OP_HALT, 0, 0, 38'h13);
        load(52, OP_HALT, 0, 0, 38'h14);
        flag_jump(2'b01, 6, "jnz_z1");
        flag_jump(2'b00, 47, "jnz_z0");
        load(5, OP_JUMPZ, 0, 52, 38'h15);
        flag_jump(2'b01, 52, "jz_z1");
        flag_jump(2'b10, 6, "jz_z0");

        // Dispatch and address wrap
        load(0, OP_NEXT, 0, 0, 38'h20);
        load(1, OP_DISPATCH, 0, 0, 38'h21);
        load(4, OP_JUMP, 0, 63, 38'h22);
        load(63, OP_NEXT, 0, 0, 38'h23);
        mbru = 6'd4;
        start_prog("dsp_start");
        cycle("dsp_c1");
        cycle("dsp_c2");
        check("dsp_upc", 64'(upc), 64'd4);
        cycle("dsp_c3");
        check("wrap_pre", 64'(upc), 64'd63);
        cycle("dsp_c4");
        check("wrap_upc", 64'(upc), 64'd0);
        do_reset("dsp_rst");

        // Stack overflow, then underflow, then restart out of ERR
        for (int i = 0; i < 5; i++) load(i, OP_CALL, 0, i + 1, 38'(i + 'h30));
        start_prog("ovf_start");
        repeat (5) cycle("ovf_c");
        check("ovf_error", 64'(error), 64'h1);
        load(0, OP_RET, 0, 0, 38'h40);
        start_prog("udf_start");
        check("udf_restart_err", 64'(error), 64'h0);
        cycle("udf_c");
        check("udf_error", 64'(error), 64'h1);
        start_prog("err_restart");
        check("err_restart_busy", 64'(busy), 64'h1);
        check("err_restart_upc", 64'(upc), 64'(START));
        do_reset("err_rst");

        // Stall mid-program
        load(0, OP_NEXT, 0, 0, 38'h1);
        load(1, OP_NEXT, 0, 0, 38'h2);
        load(2, OP_NEXT, 0, 0, 38'h3);
        load(3, OP_HALT, 0, 0, 38'h4);
        start_prog("stl_start");
        cycle("stl_c1");
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("stl_frozen");
            check("stl_upc", 64'(upc), 64'd1);
            check("stl_cs", 64'(control_signal), 64'h0);
        end
        enable = 1'b1;
        #1;
        check("stl_resume_cs", 64'(control_signal), 64'h2);
        cycle("stl_c2");
        cycle("stl_c3");
        cycle("stl_c4");
        check("stl_finish", 64'(finish), 64'h1);

        // Asynchronous reset between edges; store survives
        load(2, OP_HALT, 0, 0, 38'h3);
        start_prog("ar_start");
        cycle("ar_c1");
        #3;
        rst_n = 1'b0;
        reset_model();
        #1;
        check_all("ar_async");
        check("ar_upc0", 64'(upc), 64'h0);
        cycle("ar_hold");
        rst_n = 1'b1;
        start_prog("ar_rerun");
        check("ar_cs0", 64'(control_signal), 64'h1);
        cycle("ar_c1b");
        check("ar_cs1", 64'(control_signal), 64'h2);
        cycle("ar_c2b");
        check("ar_cs2", 64'(control_signal), 64'h3);
        cycle("ar_c3b");

        // Randomized programs and control inputs
        for (int round = 0; round < 3; round++) begin
            do_reset("rnd_rst");
            for (int i = 0; i < DEPTH; i++) begin
                r = {$urandom, $urandom};
                load(i, int'($urandom_range(7)), int'($urandom_range(1)),
                     int'($urandom_range(DEPTH - 1)), r[CW_W-1:0]);
            end
            for (int c = 0; c < 200; c++) begin
                enable  = ($urandom_range(3) != 0);
                start   = ($urandom_range(9) == 0);
                flags   = NFLAGS'($urandom);
                mbru    = UPC_W'($urandom);
                ld_en   = ($urandom_range(19) == 0);
                ld_addr = UPC_W'($urandom);
                r       = {$urandom, $urandom};
                ld_data = r[WORD_W-1:0];
                #1;
                check("rnd_cs_pre", 64'(control_signal),
                      64'((m_mode == "run" && enable) ? mem[m_upc].ctrl : '0));
                cycle("rnd");
            end
            start = 1'b0;
            ld_en = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/microseq_control_unit.md
Name: microseq_control_unit

Overview:
Parametrised microprogrammed sequencer that drives the convolution processor datapath. A loadable control store holds microwords. Each microword has control bits plus a sequencing field. The block supports conditional jumps on a selectable flag, opcode dispatch from MBRU, and a bounded CALL/RET stack. It replaces the fixed-width control unit, and sits between instruction memory (MBRU) and the datapath control inputs.

Parameters:
UPC_W, 6, micro-PC / control-store address width (store depth 2**UPC_W)
CW_W, 38, control-signal width
NFLAGS, 2, number of condition flags (bit 0 = Z)
STACK_DEPTH, 4, CALL/RET return-address stack entries (>=1)
START_ADDR, 0, micro-PC loaded on start
DISPATCH_BASE, 0, offset added to opcode on DISPATCH

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  run qualifier; low = stall (state/upc/stack frozen, control_signal forced 0)
start  in  1  begin microprogram from START_ADDR (accepted in IDLE, HALT, ERR)
flags  in  NFLAGS  condition flags, sampled on the edge that executes the current microword
MBRU  in  UPC_W  opcode for DISPATCH
ld_en  in  1  control-store write strobe (ignored in RUN)
ld_addr  in  UPC_W  control-store write address
ld_data  in  WORD_W  microword; WORD_W = 3 + FSEL_W + UPC_W + CW_W, FSEL_W = max(1, clog2(NFLAGS))
control_signal  out  CW_W  datapath controls of the current microword
upc  out  UPC_W  current micro-PC
busy  out  1  high in RUN
finish  out  1  high in HALT
error  out  1  high in ERR

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately forces state=IDLE, upc=0, sp=0, control_signal=0, busy=0, finish=0, error=0. Control-store contents are NOT cleared.
- Microword layout, MSB to LSB: op[2:0] | fsel[FSEL_W] | target[UPC_W] | ctrl[CW_W].
- Op encodings: NEXT=0, JUMP=1, JUMPZ=2 (jump if flags[fsel]=1), JUMPNZ=3 (jump if flags[fsel]=0), DISPATCH=4, CALL=5, RET=6, HALT=7.
- An fsel value >= NFLAGS reads as flag 0.
- States and transitions:
  - IDLE: start -> RUN with upc<=START_ADDR, sp<=0.
  - RUN: executes one microword per clk when enable=1.
  - HALT: reached via op HALT. finish=1 (level) until start or reset.
  - ERR: error=1 until start or reset.
  - start in HALT or ERR behaves as in IDLE.
  - start during RUN is ignored.
- control_signal = ctrl of store[upc] when state=RUN and enable=1, else 0. It is a combinational read of the registered upc, so there is zero latency from the upc change.
- Next-upc rules in RUN (all arithmetic mod 2**UPC_W):
  - NEXT: upc+1; upc=2**UPC_W-1 wraps to 0.
  - JUMP: target.
  - JUMPZ / JUMPNZ: target if the condition holds, else upc+1.
  - DISPATCH: MBRU + DISPATCH_BASE.
  - CALL: push upc+1, upc<=target. If sp=STACK_DEPTH, go to ERR and do not push.
  - RET: pop into upc. If sp=0, go to ERR.
  - HALT: upc holds, state->HALT. The HALT word's ctrl is driven for its own cycle only.
- enable=0 in RUN: nothing advances, flags are not sampled, and the instruction re-executes when enable returns.
- Loads: ld_en=1 in a non-RUN state writes store[ld_addr] on the clock edge. Writes are also accepted while rst_n=0 is released? No: writes require rst_n=1.
- start and ld_en in the same cycle: the write happens and RUN begins. The first fetched word sees the new data if ld_addr=START_ADDR.
- Reset mid-RUN aborts immediately to IDLE and the stack is discarded.

Decomposition:
- Shared package cu_pkg holds:
  - the seq-op encodings (SEQ_NEXT..SEQ_HALT)
  - the state encodings (IDLE, RUN, HALT, ERR)
  - field-width helper functions (FSEL_W, WORD_W)
  - field slice offsets
- One sub-module, cu_control_store: 2**UPC_W x WORD_W RAM with synchronous write and asynchronous read, unreset.
- Stack and sequencer stay in the top module.

Test Plan:
- Load 0:NEXT c=0x1, 1:NEXT c=0x2, 2:HALT c=0x3; start -> control_signal 0x1, 0x2, 0x3 on consecutive cycles, then finish=1, busy=0, control_signal=0.
- Word 5:JUMPNZ fsel=0 target=47. Z=1 -> upc 6; rerun with Z=0 -> upc 47. Word 5:JUMPZ target=52: Z=1 -> 52, Z=0 -> 6.
- Word 1:DISPATCH, MBRU=4, DISPATCH_BASE=0 -> upc=4 next cycle. Word at 63:NEXT -> upc wraps to 0.
- Nested CALLs 5 deep with STACK_DEPTH=4 -> 5th CALL gives error=1, state ERR. RET at sp=0 -> error=1. A subsequent start clears error and restarts at START_ADDR.
- enable low for 3 cycles mid-program -> upc frozen, control_signal=0. Sequence resumes unchanged when enable returns.
- rst_n asserted mid-RUN between edges -> outputs 0 and upc=0 asynchronously. Store contents preserved: start after release reproduces the first scenario's sequence.
